// File: rtl/mcp3008_scan_sequencer.sv
// rtl/mcp3008_scan_sequencer.sv - MCP3008 SPI scan sequencer with priority one-shot requests
// Optional macro ADC_AVG_EN: latest-value table holds a 3:1 running average instead of raw codes.
module mcp3008_scan_sequencer #(
    parameter int SCK_DIV  = 25,
    parameter int GAP_CYC  = 50,
    parameter int PRIO_MAX = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    input  logic        req_valid,
    input  logic [2:0]  req_ch,
    output logic        req_ready,
    output logic        res_valid,
    output logic [2:0]  res_ch,
    output logic        res_src,
    output logic [9:0]  res_data,
    output logic [79:0] ch_data,
    output logic        busy,
    output logic        sck,
    output logic        cs_n,
    output logic        din,
    input  logic        dout
);
    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;

    localparam logic [15:0] P_HALF     = 16'(SCK_DIV);
    localparam logic [15:0] P_LAST     = 16'(2 * SCK_DIV - 1);
    localparam logic [15:0] G_LAST     = 16'(GAP_CYC - 1);
    localparam logic [7:0]  STREAK_LIM = 8'(PRIO_MAX);

    state_t      state_q;
    logic        run_q;
    logic [15:0] p_q, g_q;
    logic [4:0]  k_q;
    logic [2:0]  ptr_q, cur_ch_q;
    logic        cur_src_q;
    logic [7:0]  streak_q;
    logic [9:0]  shift_q;
    logic        sck_q, cs_n_q, din_q, busy_q;
    logic        res_valid_q, res_src_q;
    logic [2:0]  res_ch_q;
    logic [9:0]  res_data_q;
    logic [79:0] ch_data_q;

    logic [7:0]  scan_avail;
    logic        scan_ok, prio_ok, pick_prio, pick_scan, frame_end, scan_found;
    logic [2:0]  scan_ch, scan_idx;

    function automatic logic cmd_bit(input logic [4:0] k, input logic [2:0] ch);
        case (k)
            5'd1, 5'd2: cmd_bit = 1'b1;
            5'd3:       cmd_bit = ch[2];
            5'd4:       cmd_bit = ch[1];
            5'd5:       cmd_bit = ch[0];
            default:    cmd_bit = 1'b0;
        endcase
    endfunction

    assign scan_avail = enable ? ch_mask : 8'h00;
    assign scan_ok    = |scan_avail;
    assign prio_ok    = (streak_q < STREAK_LIM) || !scan_ok;
    // run_q keeps req_ready low while reset is held and for the first clk after it.
    assign req_ready  = run_q && (state_q == S_IDLE) && prio_ok;
    assign pick_prio  = req_valid && req_ready;
    assign pick_scan  = run_q && (state_q == S_IDLE) && !pick_prio && scan_ok;
    assign frame_end  = (state_q == S_FRAME) && (p_q == P_LAST) && (k_q == 5'd17);

    always_comb begin
        scan_ch    = ptr_q;
        scan_idx   = ptr_q;
        scan_found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!scan_found && scan_avail[scan_idx]) begin
                scan_ch    = scan_idx;
                scan_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            p_q         <= '0;
            g_q         <= '0;
            k_q         <= '0;
            ptr_q       <= 3'd7;
            cur_ch_q    <= '0;
            cur_src_q   <= 1'b0;
            streak_q    <= '0;
            shift_q     <= '0;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            din_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_src_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            run_q       <= 1'b1;
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_prio || pick_scan) begin
                        state_q   <= S_FRAME;
                        busy_q    <= 1'b1;
                        cs_n_q    <= 1'b0;
                        din_q     <= 1'b1;
                        sck_q     <= 1'b0;
                        p_q       <= '0;
                        k_q       <= 5'd1;
                        cur_src_q <= pick_prio;
                        if (pick_prio) begin
                            cur_ch_q <= req_ch;
                            if (streak_q < STREAK_LIM) streak_q <= streak_q + 8'd1;
                        end else begin
                            cur_ch_q <= scan_ch;
                            ptr_q    <= scan_ch;
                            streak_q <= '0;
                        end
                    end
                end
                S_FRAME: begin
                    // Periods 6 and 7 carry the sample window and null bit; data starts at 8.
                    if (p_q == P_HALF && k_q >= 5'd8) shift_q <= {shift_q[8:0], dout};
                    if (p_q == P_LAST) begin
                        p_q   <= '0;
                        sck_q <= 1'b0;
                        if (k_q == 5'd17) begin
                            state_q     <= S_GAP;
                            g_q         <= '0;
                            cs_n_q      <= 1'b1;
                            din_q       <= 1'b0;
                            res_valid_q <= 1'b1;
                            res_ch_q    <= cur_ch_q;
                            res_src_q   <= cur_src_q;
                            res_data_q  <= shift_q;
                        end else begin
                            k_q   <= k_q + 5'd1;
                            din_q <= cmd_bit(k_q + 5'd1, cur_ch_q);
                        end
                    end else begin
                        p_q <= p_q + 16'd1;
                        if (p_q == P_HALF - 16'd1) sck_q <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (g_q == G_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        g_q <= g_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [6:0] tbl_base;
    logic [9:0] tbl_new;
    assign tbl_base = {1'b0, cur_ch_q, 3'b000} + {3'b000, cur_ch_q, 1'b0};

`ifdef ADC_AVG_EN
    logic [7:0]  seen_q;
    logic [9:0]  tbl_old;
    logic [11:0] avg_sum;
    assign tbl_old = ch_data_q[tbl_base +: 10];
    assign avg_sum = 12'd3 * {2'b00, tbl_old} + {2'b00, shift_q} + 12'd2;
    assign tbl_new = seen_q[cur_ch_q] ? 10'(avg_sum >> 2) : shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else if (frame_end) begin
            seen_q[cur_ch_q] <= 1'b1;
        end
    end
`else
    assign tbl_new = shift_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data_q <= '0;
        end else if (frame_end) begin
            ch_data_q[tbl_base +: 10] <= tbl_new;
        end
    end

    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_src   = res_src_q;
    assign res_data  = res_data_q;
    assign ch_data   = ch_data_q;
    assign busy      = busy_q;
    assign sck       = sck_q;
    assign cs_n      = cs_n_q;
    assign din       = din_q;
endmodule

// File: tb/tb_mcp3008_scan_sequencer.sv
// tb/tb_mcp3008_scan_sequencer.sv - randomized self-checking bench for mcp3008_scan_sequencer
module tb_mcp3008_scan_sequencer;
    localparam int SD         = 4;
    localparam int GAP        = 6;
    localparam int PMAX       = 2;
    localparam int FRAME_CLKS = 34 * SD;
    localparam int BUDGET     = 4 * (FRAME_CLKS + GAP + 1);

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, req_valid = 1'b0, dout = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [2:0]  req_ch = 3'd0;
    logic        req_ready, res_valid, res_src, busy, sck, cs_n, din;
    logic [2:0]  res_ch;
    logic [9:0]  res_data;
    logic [79:0] ch_data;

    mcp3008_scan_sequencer #(.SCK_DIV(SD), .GAP_CYC(GAP), .PRIO_MAX(PMAX)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
        .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
        .res_valid(res_valid), .res_ch(res_ch), .res_src(res_src), .res_data(res_data),
        .ch_data(ch_data), .busy(busy), .sck(sck), .cs_n(cs_n), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    typedef struct { logic [2:0] ch; logic src; logic [9:0] data; } res_t;
    typedef struct { logic [2:0] ch; logic [4:0] bits; int rises; int low; } frm_t;
    res_t res_q[$];
    frm_t frm_q[$];

    logic [9:0] adc_val [8];
    int         rise_cnt = 0, low_cnt = 0;
    logic [4:0] din_bits = '0;
    logic [2:0] adc_ch = '0, sent_ch = '0;
    logic [9:0] adc_word = '0, sent_val = '0;
    int         model_tbl [8];
`ifdef ADC_AVG_EN
    bit         model_seen [8];
`endif
    int         mdl_ptr = 7, mdl_streak = 0;

    // ADC model: decodes the channel from din, returns adc_val[ch] MSB first.
    always @(negedge cs_n) begin
        rise_cnt = 0; din_bits = '0; dout = 1'b0; low_cnt = 0;
    end
    always @(posedge sck) if (cs_n === 1'b0) begin
        rise_cnt++;
        if (rise_cnt <= 5) din_bits = {din_bits[3:0], din};
        if (rise_cnt == 5) begin adc_ch = din_bits[2:0]; adc_word = adc_val[adc_ch]; end
        if (rise_cnt == 17) begin sent_ch = adc_ch; sent_val = adc_word; end
    end
    always @(negedge sck) if (cs_n === 1'b0) begin
        int nk;
        nk = rise_cnt + 1;
        dout = (nk >= 8 && nk <= 17) ? adc_word[17 - nk] : 1'b0;
    end
    always @(posedge cs_n) begin
        frm_q.push_back('{adc_ch, din_bits, rise_cnt, low_cnt});
        dout = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && cs_n === 1'b0) low_cnt++;
        if (res_valid === 1'b1) begin
            res_q.push_back('{res_ch, res_src, res_data});
`ifdef ADC_AVG_EN
            if (model_seen[sent_ch]) model_tbl[sent_ch] = (3 * model_tbl[sent_ch] + int'(sent_val) + 2) / 4;
            else                     model_tbl[sent_ch] = int'(sent_val);
            model_seen[sent_ch] = 1'b1;
`else
            model_tbl[sent_ch] = int'(sent_val);
`endif
        end
    end

    function automatic logic [79:0] model_pack();
        logic [79:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[10*c +: 10] = 10'(model_tbl[c]);
        return v;
    endfunction

    function automatic int next_scan(input int ptr, input logic [7:0] m);
        for (int i = 1; i <= 8; i++) if (m[(ptr + i) % 8]) return (ptr + i) % 8;
        return ptr;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 8; c++) begin
            model_tbl[c] = 0;
`ifdef ADC_AVG_EN
            model_seen[c] = 1'b0;
`endif
        end
        mdl_ptr = 7; mdl_streak = 0;
    endtask

    task automatic wait_results(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET * n; i++) begin
            @(negedge clk); #1;
            if (res_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk); #1;
            if (busy === 1'b0 && cs_n === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send_req(input logic [2:0] ch, output bit ok);
        ok = 1'b0;
        @(negedge clk); req_valid = 1'b1; req_ch = ch;
        for (int i = 0; i < BUDGET; i++) begin
            #1;
            if (req_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk); req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if ({cs_n, sck, din, req_ready, res_valid, busy} !== 6'b100000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 100000", {cs_n, sck, din, req_ready, res_valid, busy});
        end
        total++; if ({res_ch, res_src, res_data} !== 14'h0) begin
            bad++; $display("FAIL reset_res: got %h want 0", {res_ch, res_src, res_data});
        end
        total++; if (ch_data !== 80'h0) begin
            bad++; $display("FAIL reset_ch_data: got %h want 0", ch_data);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if ({req_ready, busy, cs_n} !== 3'b101) begin
            bad++; $display("FAIL reset_release: got ready/busy/cs_n %b want 101", {req_ready, busy, cs_n});
        end
        clear_model(); res_q.delete(); frm_q.delete();
    endtask

    task automatic test_scan_order();
        bit ok;
        int e;
        adc_val[1] = 10'h155; adc_val[5] = 10'h2AA;
        res_q.delete(); frm_q.delete();
        @(negedge clk); ch_mask = 8'h22; enable = 1'b1;
        wait_results(4, ok);
        enable = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL scan_timeout: got %0d results want 4", res_q.size()); end
        for (int d = 0; d < 4; d++) begin
            e = next_scan(mdl_ptr, 8'h22); mdl_ptr = e; mdl_streak = 0;
            if (d < res_q.size()) begin
                total++; if ({res_q[d].ch, res_q[d].src, res_q[d].data} !== {3'(e), 1'b0, adc_val[e]}) begin
                    bad++; $display("FAIL scan_res%0d: got ch=%0d src=%0d data=%h want ch=%0d src=0 data=%h",
                                    d, res_q[d].ch, res_q[d].src, res_q[d].data, e, adc_val[e]);
                end
            end
        end
        wait_idle(ok);
        total++; if (ch_data[19:10] !== 10'h155) begin
            bad++; $display("FAIL scan_ch1_table: got %h want 155", ch_data[19:10]);
        end
        total++; if (ch_data !== model_pack()) begin
            bad++; $display("FAIL scan_table: got %h want %h", ch_data, model_pack());
        end
    endtask

    task automatic test_arbitration();
        bit ok;
        int dec, acc, macc, e;
        bit rdy_log [6];
        bit exp_rdy [6];
        int exp_ch [6];
        bit exp_src [6];
        bit rq, rd;
        macc = 0;
        for (int d = 0; d < 6; d++) begin
            rq = (macc < 4);
            rd = (mdl_streak < PMAX);
            exp_rdy[d] = rd;
            if (rq && rd) begin
                exp_ch[d] = 3; exp_src[d] = 1'b1; mdl_streak++; macc++;
            end else begin
                e = next_scan(mdl_ptr, 8'h01); mdl_ptr = e;
                exp_ch[d] = e; exp_src[d] = 1'b0; mdl_streak = 0;
            end
        end
        for (int c = 0; c < 8; c++) adc_val[c] = 10'($urandom);
        res_q.delete(); frm_q.delete();
        dec = 0; acc = 0;
        @(negedge clk); enable = 1'b1; ch_mask = 8'h01; req_ch = 3'd3; req_valid = 1'b1;
        for (int i = 0; i < 6 * BUDGET && res_q.size() < 6; i++) begin
            #1;
            if (busy === 1'b0 && dec < 6) begin
                rdy_log[dec] = req_ready; dec++;
                if (req_valid && req_ready) acc++;
            end
            @(negedge clk);
            if (acc >= 4) req_valid = 1'b0;
        end
        enable = 1'b0; req_valid = 1'b0;
        wait_idle(ok);
        total++; if (res_q.size() != 6 || dec != 6) begin
            bad++; $display("FAIL arb_count: got results=%0d decisions=%0d want 6/6", res_q.size(), dec);
        end
        for (int d = 0; d < dec; d++) begin
            total++; if (rdy_log[d] !== exp_rdy[d]) begin
                bad++; $display("FAIL arb_ready%0d: got %0d want %0d", d, rdy_log[d], exp_rdy[d]);
            end
        end
        for (int d = 0; d < res_q.size() && d < 6; d++) begin
            total++; if ({res_q[d].ch, res_q[d].src, res_q[d].data} !== {3'(exp_ch[d]), exp_src[d], adc_val[exp_ch[d]]}) begin
                bad++; $display("FAIL arb_res%0d: got ch=%0d src=%0d data=%h want ch=%0d src=%0d data=%h",
                                d, res_q[d].ch, res_q[d].src, res_q[d].data, exp_ch[d], exp_src[d], adc_val[exp_ch[d]]);
            end
        end
        total++; if (ch_data !== model_pack()) begin
            bad++; $display("FAIL arb_table: got %h want %h", ch_data, model_pack());
        end
    endtask

    task automatic test_cmd_bits();
        bit ok, ok2;
        logic [2:0] ch;
        ch = 3'd6;
        for (int c = 0; c < 8; c++) adc_val[c] = 10'($urandom);
        ch_mask = 8'($urandom); enable = 1'b0;
        res_q.delete(); frm_q.delete();
        send_req(ch, ok);
        wait_results(1, ok2);
        mdl_streak++;
        total++; if (!(ok && ok2)) begin bad++; $display("FAIL cmd_timeout: got accept=%0d result=%0d want 1/1", ok, ok2); end
        wait_idle(ok);
        total++; if (frm_q.size() != 1) begin bad++; $display("FAIL cmd_frames: got %0d want 1", frm_q.size()); end
        if (frm_q.size() >= 1) begin
            total++; if (frm_q[0].bits !== {2'b11, ch}) begin
                bad++; $display("FAIL cmd_din_bits: got %b want %b", frm_q[0].bits, {2'b11, ch});
            end
            total++; if (frm_q[0].rises != 17 || frm_q[0].low != FRAME_CLKS) begin
                bad++; $display("FAIL cmd_timing: got rises=%0d low=%0d want 17/%0d", frm_q[0].rises, frm_q[0].low, FRAME_CLKS);
            end
        end
        if (res_q.size() >= 1) begin
            total++; if ({res_q[0].ch, res_q[0].src, res_q[0].data} !== {ch, 1'b1, adc_val[ch]}) begin
                bad++; $display("FAIL cmd_res: got ch=%0d src=%0d data=%h want ch=%0d src=1 data=%h",
                                res_q[0].ch, res_q[0].src, res_q[0].data, ch, adc_val[ch]);
            end
        end
    endtask

    task automatic test_idle_prio();
        bit ok, ok2;
        for (int c = 0; c < 8; c++) adc_val[c] = 10'($urandom);
        ch_mask = 8'($urandom); enable = 1'b0;
        res_q.delete(); frm_q.delete();
        @(negedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", req_ready); end
        send_req(3'd7, ok);
        wait_results(1, ok2);
        mdl_streak++;
        total++; if (!(ok && ok2)) begin bad++; $display("FAIL idle_timeout: got accept=%0d result=%0d want 1/1", ok, ok2); end
        repeat (3 * FRAME_CLKS) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0 || cs_n !== 1'b1 || frm_q.size() != 1 || res_q.size() != 1) begin
            bad++; $display("FAIL idle_quiet: got busy=%b cs_n=%b frames=%0d results=%0d want 0/1/1/1",
                            busy, cs_n, frm_q.size(), res_q.size());
        end
        if (res_q.size() >= 1) begin
            total++; if ({res_q[0].ch, res_q[0].src, res_q[0].data} !== {3'd7, 1'b1, adc_val[7]}) begin
                bad++; $display("FAIL idle_res: got ch=%0d src=%0d data=%h want ch=7 src=1 data=%h",
                                res_q[0].ch, res_q[0].src, res_q[0].data, adc_val[7]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int n0, e;
        logic [7:0] m;
        m = 8'($urandom_range(1, 255));
        for (int c = 0; c < 8; c++) adc_val[c] = 10'($urandom);
        res_q.delete(); frm_q.delete();
        @(negedge clk); ch_mask = m; enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (cs_n === 1'b0 && rise_cnt == 10) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid_reach_k10: got rise_cnt=%0d want 10", rise_cnt); end
        rst_n = 1'b0;
        #1;
        total++; if ({cs_n, sck, din, res_valid} !== 4'b1000) begin
            bad++; $display("FAIL rstmid_async: got cs_n/sck/din/res_valid %b want 1000", {cs_n, sck, din, res_valid});
        end
        n0 = res_q.size();
        clear_model();
        repeat (3) @(negedge clk);
        total++; if (res_q.size() != n0 || ch_data !== 80'h0) begin
            bad++; $display("FAIL rstmid_discard: got new results=%0d ch_data=%h want 0/0", res_q.size() - n0, ch_data);
        end
        rst_n = 1'b1;
        res_q.delete(); frm_q.delete();
        wait_results(1, ok);
        enable = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout: got no result want 1"); end
        wait_idle(ok);
        e = next_scan(7, m); mdl_ptr = e;
        if (frm_q.size() >= 1) begin
            total++; if (frm_q[0].rises != 17 || frm_q[0].low != FRAME_CLKS || frm_q[0].ch !== 3'(e)) begin
                bad++; $display("FAIL rstmid_frame: got rises=%0d low=%0d ch=%0d want 17/%0d/%0d",
                                frm_q[0].rises, frm_q[0].low, frm_q[0].ch, FRAME_CLKS, e);
            end
        end
        if (res_q.size() >= 1) begin
            total++; if ({res_q[0].ch, res_q[0].src, res_q[0].data} !== {3'(e), 1'b0, adc_val[e]}) begin
                bad++; $display("FAIL rstmid_res: got ch=%0d src=%0d data=%h want ch=%0d src=0 data=%h",
                                res_q[0].ch, res_q[0].src, res_q[0].data, e, adc_val[e]);
            end
        end
    endtask

    task automatic test_averaging();
        bit ok, ok2;
        int want2;
`ifdef ADC_AVG_EN
        want2 = 500;
`else
        want2 = 800;
`endif
        enable = 1'b0;
        for (int r = 0; r < 2; r++) begin
            adc_val[2] = (r == 0) ? 10'd400 : 10'd800;
            res_q.delete(); frm_q.delete();
            send_req(3'd2, ok);
            wait_results(1, ok2);
            wait_idle(ok);
            total++; if (!ok2 || res_q.size() < 1) begin
                bad++; $display("FAIL avg_timeout%0d: got no result want 1", r);
            end else begin
                total++; if (res_q[0].data !== adc_val[2]) begin
                    bad++; $display("FAIL avg_raw%0d: got %0d want %0d", r, res_q[0].data, adc_val[2]);
                end
            end
            total++; if (ch_data[29:20] !== 10'(model_tbl[2])) begin
                bad++; $display("FAIL avg_model%0d: got %0d want %0d", r, ch_data[29:20], model_tbl[2]);
            end
        end
        total++; if (ch_data[29:20] !== 10'(want2)) begin
            bad++; $display("FAIL avg_final: got %0d want %0d", ch_data[29:20], want2);
        end
    endtask

    initial begin
        for (int c = 0; c < 8; c++) adc_val[c] = 10'($urandom);
        clear_model();
        test_reset();
        test_scan_order();
        test_arbitration();
        test_cmd_bits();
        test_idle_prio();
        test_reset_midframe();
        test_averaging();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
